// File: rtl/controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Covers the state enum, opcodes, ALU control codes and datapath mux select codes.
package controller_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBranch,
        StJal,
        StHalt
    } state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResData      = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // Immediate format follows the opcode alone, independent of FSM state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OpStore:  imm_src = ImmS;
            OpBranch: imm_src = ImmB;
            OpJal:    imm_src = ImmJ;
            default:  imm_src = ImmI;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALUOp and the instruction fields.
module alu_decoder
    import controller_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        unique case (alu_op_i)
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                case (funct3_i)
                    // op[5] separates R-type sub from I-type addi with imm[10] set.
                    3'b000:  alu_control_o = (op5_i && funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences a shared memory port and single ALU.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module multicycle_controller
    import controller_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [2:0]           ALUControl,
    output logic                 Retire,
    output logic                 Halted,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instret_count
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = ResAluOut;
        ALUSrcA   = SrcAPc;
        ALUSrcB   = SrcBRs2;
        alu_op    = AluOpAdd;
        Retire    = 1'b0;
        Halted    = 1'b0;

        unique case (state_q)
            StFetch: begin
                ALUSrcB   = SrcBFour;
                ResultSrc = ResAluResult;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = StDecode;
            end
            StDecode: begin
                // Precompute the branch target from OldPC while the opcode is decoded.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBImm;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecR;
                    OpIAlu:          state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    default:         state_d = StHalt;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = StMemWb;
            end
            StMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                Retire   = MemReady;
                if (MemReady) state_d = StFetch;
            end
            StMemWb: begin
                ResultSrc = ResData;
                RegWrite  = 1'b1;
                Retire    = 1'b1;
                state_d   = StFetch;
            end
            StExecR: begin
                ALUSrcA = SrcARs1;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StExecI: begin
                ALUSrcA = SrcARs1;
                ALUSrcB = SrcBImm;
                alu_op  = AluOpFunct;
                state_d = StAluWb;
            end
            StAluWb: begin
                RegWrite = 1'b1;
                Retire   = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA = SrcARs1;
                alu_op  = AluOpSub;
                PCWrite = Zero;
                Retire  = 1'b1;
                state_d = StFetch;
            end
            StJal: begin
                // Jump target was latched in ALUOut during decode; PC+4 goes to rd via ALUWB.
                ALUSrcA = SrcAOldPc;
                ALUSrcB = SrcBFour;
                PCWrite = 1'b1;
                state_d = StAluWb;
            end
            StHalt: begin
                Halted = 1'b1;
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        if (reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            Retire   = 1'b0;
            Halted   = 1'b0;
        end
    end

    assign ImmSrc = imm_src(op);

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (op[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALUControl)
    );

`ifdef PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cycle_q, instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else if (state_q != StHalt) begin
            cycle_q <= cycle_q + CntOne;
            if (Retire) instret_q <= instret_q + CntOne;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule
